// File: rtl/scramble_lane_pipe.sv
// Per-lane Gen1/Gen2 scrambler/descrambler with COM/SKP/K/TS handling and scramble sync.
// One register stage sits between In* and Out*. The function is symmetric, so the same block descrambles.
module scramble_lane_pipe #(
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter logic [7:0]  COM_SYM = 8'hBC,
    parameter logic [7:0]  SKP_SYM = 8'h1C
) (
    input  logic        ClkPci,
    input  logic        ResetPci,
    input  logic        Enable,
    input  logic        InValid,
    input  logic [7:0]  InData,
    input  logic        InCtrl,
    input  logic        InTsData,
    output logic        OutValid,
    output logic [7:0]  OutData,
    output logic        OutCtrl,
    output logic        OutSync,
    output logic [15:0] LfsrState
);

    localparam logic [0:0] UNSYNC = 1'b0;
    localparam logic [0:0] SYNC   = 1'b1;

    // Eight serial shifts of X^16+X^5+X^4+X^3+1 collapsed into one step.
    function automatic logic [15:0] lfsrAdvance(input logic [15:0] l);
        logic [15:0] h;
        h = {8'h00, l[15:8]};
        return {l[7:0], l[15:8]} ^ (h << 3) ^ (h << 4) ^ (h << 5);
    endfunction

    function automatic logic [7:0] bitRev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    logic [15:0] lfsr, lfsrNext;
    logic [0:0]  state, stateNext;
    logic [7:0]  dataNext;
    logic        isCom, isSkp;

    assign isCom = InCtrl && (InData == COM_SYM);
    assign isSkp = InCtrl && (InData == SKP_SYM);

    always_comb begin
        lfsrNext  = lfsrAdvance(lfsr);
        stateNext = state;
        dataNext  = InData;
        if (isCom) begin
            lfsrNext  = SEED;
            stateNext = SYNC;
        end else if (isSkp) begin
            lfsrNext = lfsr;
        end else if (!InCtrl && !InTsData && Enable && state == SYNC) begin
            dataNext = InData ^ bitRev8(lfsr[15:8]);
        end
    end

    // A stall freezes sequencing; the data path keeps its last symbol.
    always_ff @(posedge ClkPci) begin
        if (ResetPci) begin
            lfsr     <= SEED;
            state    <= UNSYNC;
            OutValid <= 1'b0;
            OutData  <= 8'h00;
            OutCtrl  <= 1'b0;
        end else begin
            OutValid <= InValid;
            if (InValid) begin
                lfsr    <= lfsrNext;
                state   <= stateNext;
                OutData <= dataNext;
                OutCtrl <= InCtrl;
            end
        end
    end

    assign OutSync   = (state == SYNC);
    assign LfsrState = lfsr;

endmodule

// File: tb/tb_scramble_lane_pipe.sv
// Directed-vector bench for scramble_lane_pipe; expected bytes are the hand-derived scrambler sequence.
// The sequence begins FF 17 C0 14 B2 E7 02 82 72 6E 28 A6 BE 6D BF 8D.
module tb_scramble_lane_pipe;

    logic        ClkPci = 1'b0;
    logic        ResetPci = 1'b1;
    logic        Enable = 1'b1;
    logic        InValid = 1'b0;
    logic [7:0]  InData = 8'h00;
    logic        InCtrl = 1'b0;
    logic        InTsData = 1'b0;
    logic        OutValid;
    logic [7:0]  OutData;
    logic        OutCtrl;
    logic        OutSync;
    logic [15:0] LfsrState;

    int nVec = 0;
    int nErr = 0;

    scramble_lane_pipe dut (
        .ClkPci(ClkPci), .ResetPci(ResetPci), .Enable(Enable),
        .InValid(InValid), .InData(InData), .InCtrl(InCtrl), .InTsData(InTsData),
        .OutValid(OutValid), .OutData(OutData), .OutCtrl(OutCtrl),
        .OutSync(OutSync), .LfsrState(LfsrState)
    );

    always #5 ClkPci = ~ClkPci;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic step(input logic v, input logic c, input logic t, input logic [7:0] d);
        InValid  = v;
        InCtrl   = c;
        InTsData = t;
        InData   = d;
        @(posedge ClkPci);
        #1;
    endtask

    task automatic com();
        step(1'b1, 1'b1, 1'b0, 8'hBC);
    endtask

    task automatic dsym(input logic [7:0] d, input logic [7:0] exp, input string tag);
        step(1'b1, 1'b0, 1'b0, d);
        chk(tag, {24'h0, OutData}, {24'h0, exp});
        chk({tag, "_ctrl"}, {31'h0, OutCtrl}, 32'h0);
    endtask

    initial begin
        #1;
        step(1'b1, 1'b1, 1'b0, 8'hBC);
        step(1'b1, 1'b0, 1'b0, 8'h55);
        chk("rst_valid", {31'h0, OutValid}, 32'h0);
        chk("rst_data",  {24'h0, OutData}, 32'h0);
        chk("rst_ctrl",  {31'h0, OutCtrl}, 32'h0);
        chk("rst_sync",  {31'h0, OutSync}, 32'h0);
        chk("rst_lfsr",  {16'h0, LfsrState}, 32'hFFFF);
        ResetPci = 1'b0;

        // Direct sequence after COM
        com();
        chk("com_data",  {24'h0, OutData}, 32'hBC);
        chk("com_ctrl",  {31'h0, OutCtrl}, 32'h1);
        chk("com_valid", {31'h0, OutValid}, 32'h1);
        chk("com_sync",  {31'h0, OutSync}, 32'h1);
        chk("com_lfsr",  {16'h0, LfsrState}, 32'hFFFF);
        dsym(8'h00, 8'hFF, "seq0");
        chk("seq0_lfsr", {16'h0, LfsrState}, 32'hE817);
        dsym(8'h00, 8'h17, "seq1");
        dsym(8'h00, 8'hC0, "seq2");
        chk("seq2_lfsr", {16'h0, LfsrState}, 32'h284B);

        // SKP holds the LFSR
        com();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h1C);
            chk("skp_data", {24'h0, OutData}, 32'h1C);
            chk("skp_ctrl", {31'h0, OutCtrl}, 32'h1);
            chk("skp_lfsr", {16'h0, LfsrState}, 32'hFFFF);
        end
        dsym(8'h00, 8'hFF, "skp_after");

        // Stall
        com();
        dsym(8'h00, 8'hFF, "stall_pre");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            chk("stall_valid", {31'h0, OutValid}, 32'h0);
            chk("stall_lfsr",  {16'h0, LfsrState}, 32'hE817);
            chk("stall_data",  {24'h0, OutData}, 32'hFF);
        end
        dsym(8'h00, 8'h17, "stall_post");
        chk("stall_post_valid", {31'h0, OutValid}, 32'h1);

        // TS body bypass, LFSR keeps advancing
        com();
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h4A);
            chk("ts_data", {24'h0, OutData}, 32'h4A);
        end
        dsym(8'h00, 8'h8D, "ts_after");
        chk("ts_after_lfsr", {16'h0, LfsrState}, 32'h7D09);

        // Enable low: pass-through but LFSR tracks
        Enable = 1'b0;
        com();
        dsym(8'h00, 8'h00, "dis0");
        dsym(8'h00, 8'h00, "dis1");
        Enable = 1'b1;
        dsym(8'h00, 8'hC0, "dis_reen");

        // Other K symbol advances the LFSR
        com();
        step(1'b1, 1'b1, 1'b0, 8'hFC);
        chk("k_data", {24'h0, OutData}, 32'hFC);
        chk("k_ctrl", {31'h0, OutCtrl}, 32'h1);
        chk("k_lfsr", {16'h0, LfsrState}, 32'hE817);
        dsym(8'h00, 8'h17, "k_after");

        // Data before any COM
        ResetPci = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h33);
        ResetPci = 1'b0;
        dsym(8'h5A, 8'h5A, "unsync_data");
        chk("unsync_sync", {31'h0, OutSync}, 32'h0);
        chk("unsync_lfsr", {16'h0, LfsrState}, 32'hE817);

        // Reset pulsed mid-stream
        com();
        dsym(8'h00, 8'hFF, "mid_pre");
        ResetPci = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("mid_valid", {31'h0, OutValid}, 32'h0);
        chk("mid_data",  {24'h0, OutData}, 32'h0);
        chk("mid_ctrl",  {31'h0, OutCtrl}, 32'h0);
        chk("mid_sync",  {31'h0, OutSync}, 32'h0);
        chk("mid_lfsr",  {16'h0, LfsrState}, 32'hFFFF);
        ResetPci = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/scramble_lane_pipe.md
Name: scramble_lane_pipe

Overview:
Per-lane 8b/10b-domain scrambling stage for the PCIe physical layer. It sits directly downstream of the 16-bit LFSR generator and upstream of the 8b/10b encoder on transmit, or downstream of the decoder on receive. The function is symmetric, so the same block descrambles.
It applies the Gen1/Gen2 symbol rules: COM reset, SKP hold, K-symbol and TS-data bypass, and stall. It holds its own LFSR state, register-stages the result, and reports lane scramble sync.

Parameters:
SEED, 16'hFFFF, LFSR value loaded on reset and on every COM
COM_SYM, 8'hBC, K28.5 code (with K flag set)
SKP_SYM, 8'h1C, K28.0 code (with K flag set)

Ports:
ClkPci  input  1  lane symbol clock
ResetPci  input  1  synchronous, active-high reset
Enable  input  1  1 = scramble D symbols; 0 = scrambling disabled (training control bit)
InValid  input  1  symbol present this cycle; 0 = stall (MovePipe equivalent)
InData  input  8  symbol byte
InCtrl  input  1  1 = K symbol
InTsData  input  1  D symbol belongs to TS1/TS2 body (from ordered-set generator/detector)
OutValid  output  1  registered InValid
OutData  output  8  scrambled/descrambled byte
OutCtrl  output  1  registered InCtrl
OutSync  output  1  1 once a COM has been processed since reset
LfsrState  output  16  current LFSR state (debug/checker)

Behaviour:
- Polynomial is G(X)=X^16+X^5+X^4+X^3+1. One advance is 8 serial shifts: Next = rot8(L) ^ (L[15:8]<<3) ^ (L[15:8]<<4) ^ (L[15:8]<<5), truncated to 16 bits.
- The XOR byte for a symbol is bit-reverse(L[15:8]) of the current state, i.e. {L[8],L[9],...,L[15]}. It is used first, and then the LFSR advances.
- Reset (ResetPci=1 at a ClkPci edge):
  - LFSR=SEED, state=UNSYNC.
  - OutValid=0, OutData=0, OutCtrl=0, OutSync=0.
  - Reset has priority over all other inputs, including mid-ordered-set.
- State machine: UNSYNC -> SYNC on the first valid COM. SYNC is held until reset; OutSync=1 in SYNC.
- Per valid symbol, evaluated in priority order:
  1. InCtrl=1 and InData=COM_SYM: output unmodified; LFSR<=SEED (no advance).
  2. InCtrl=1 and InData=SKP_SYM: output unmodified; LFSR held.
  3. Any other K symbol: output unmodified; LFSR advances.
  4. D symbol with InTsData=1: output unmodified; LFSR advances.
  5. D symbol, Enable=1, state=SYNC: OutData=InData^XOR; LFSR advances.
  6. D symbol, Enable=0 or state=UNSYNC: output unmodified; LFSR advances.
- InValid=0: LFSR and state are held. OutValid<=0. OutData/OutCtrl keep their last values.
- Latency is exactly 1 ClkPci cycle from input to Out*. There is no back-pressure; one symbol is accepted per valid cycle.
- Enable is sampled per symbol. Toggling it mid-stream never disturbs LFSR sequencing.
- LfsrState reflects the registered state after the symbol's update.

Test Plan:
- Reset, then COM, then D 00,00,00 -> OutData BC(K), FF, 17, C0; OutSync=1 from the COM output cycle; LfsrState=FFFF after the COM.
- COM, SKP, SKP, SKP, then D 00 -> SKPs pass as 1C(K) with LfsrState FFFF throughout; the first data byte outputs FF.
- COM, D 00 with InValid low for 3 cycles, then D 00 -> outputs FF then 17; OutValid low during the stall; LfsrState constant during the stall.
- COM, 15 D symbols with InTsData=1 (4A), then D 00 -> the TS bytes pass unchanged; the following byte is XORed with the 16th sequence byte (same value as the direct-sequence run at index 15).
- Enable=0: COM, D 00,00 -> outputs 00,00. Then Enable=1 on the next D 00 -> output C0, proving the LFSR tracked while disabled.
- Data before any COM -> unscrambled output with OutSync=0. ResetPci pulsed mid-stream -> all outputs 0 next cycle, LfsrState=FFFF, OutSync=0.
